u_game_ctrl: RTL
================

U_GAME_CTRL -- requirements
Module: u_game_ctrl

Interface
REQ-001 Parameter MATCH_POINTS, default 5: round wins needed to end the match.
REQ-002 Parameter MIN_WAIT_MS, default 1000: minimum random pre-GO delay in ticks.
REQ-003 Parameter TIMEOUT_MS, default 2000: maximum GO window in ticks.
REQ-004 Port clk, input, 1: system clock; the block has one clock.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port i_tick, input, 1: 1 ms enable pulse, one clk wide.
REQ-007 Port i_start, input, 1: debounced one-shot start/next-round request.
REQ-008 Port i_restart, input, 1: debounced one-shot full restart.
REQ-009 Port i_play, input, 2: debounced one-shots; bit0 = left player, bit1 = right player.
REQ-010 Port o_state, output, 3: current FSM state code.
REQ-011 Port o_go, output, 1: GO lamp, high only in state GO.
REQ-012 Port o_winner, output, 2: last round result; 01 = L, 10 = R, 11 = tie, 00 = none.
REQ-013 Port o_foul, output, 2: last round foul flags per player.
REQ-014 Port o_react_ms, output, 11: last round reaction time in ticks.
REQ-015 Port o_score_l and o_score_r, output, 4 each: match scores.
REQ-016 Port o_match_over, output, 1: high in state OVER.

Function
REQ-017 States SHALL be IDLE=0, WAIT=1, GO=2, RESULT=3, FOUL=4, OVER=5; every transition takes effect on the clk edge at which the cause is sampled.
REQ-018 IDLE: on i_start, the block SHALL load wait_cnt = MIN_WAIT_MS + lfsr[10:0] (range 1000..3047), clear o_winner, o_foul and o_react_ms, and go to WAIT.
REQ-019 WAIT: wait_cnt SHALL decrement on each i_tick; when it reaches 0 the block SHALL go to GO and clear react_cnt.
REQ-020 WAIT: any i_play bit high SHALL set the matching o_foul bit, award one point to the other player, and go to FOUL; if both bits are high, both foul bits SHALL be set, no point is awarded, and the block goes to FOUL.
REQ-021 GO: react_cnt SHALL increment on each i_tick, saturating at TIMEOUT_MS.
REQ-022 GO, first cycle with any i_play bit set: o_winner SHALL be set to i_play, o_react_ms to react_cnt, and the state to RESULT; a single winner SHALL score 1 point; a tie (11) SHALL score nothing.
REQ-023 GO, when react_cnt reaches TIMEOUT_MS with no press: o_winner SHALL be 00, o_react_ms SHALL be TIMEOUT_MS, no score is awarded, and the state goes to RESULT.
REQ-024 Scores SHALL saturate at MATCH_POINTS; the cycle after entering RESULT or FOUL, if either score equals MATCH_POINTS, the state SHALL become OVER.
REQ-025 RESULT/FOUL: i_start SHALL begin a new round exactly as in REQ-018, with scores kept; i_play SHALL be ignored.
REQ-026 OVER: only i_restart has effect.
REQ-027 i_restart in any state SHALL return to IDLE and clear the scores, o_winner, o_foul and o_react_ms; it has priority over all simultaneous inputs.
REQ-028 i_start in WAIT, GO or OVER SHALL be ignored.
REQ-029 i_tick coincident with a press in GO: the press SHALL win, and o_react_ms SHALL take the pre-increment value.
REQ-030 LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 0xACE1; it SHALL advance every clk, independent of state, and SHALL never reach all-zero.

Reset
REQ-031 On rst, state SHALL be IDLE, all outputs 0, all counters 0, and the LFSR = 0xACE1.
REQ-032 rst mid-round SHALL discard the round with no score change beyond the clear to 0.

Structure
REQ-033 The state encodings, winner codes and the default parameter values SHALL reside in the shared package game_pkg.
REQ-034 The LFSR SHALL be a separate sub-module, u_lfsr16 (ports clk, rst, o_rnd[15:0]).

Verification
REQ-035 Reset, i_start, no press: o_go SHALL rise after 1000..3047 ticks, then RESULT with o_winner=00 and o_react_ms=2000 after 2000 more ticks.
REQ-036 Left press 150 ticks after o_go rises: o_winner=01, o_react_ms=150, o_score_l=1, state=RESULT.
REQ-037 Right press during WAIT: o_foul=10, o_score_l=1, state=FOUL, o_go never asserted.
REQ-038 Both presses in the same cycle in GO: o_winner=11, scores unchanged.
REQ-039 Left wins 5 rounds: o_score_l=5, o_match_over=1; i_start is ignored; i_restart then gives IDLE with scores 0.
REQ-040 i_restart in the same cycle as i_play in GO: the block SHALL go to IDLE with no score change recorded.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the reaction-game controller: state codes, winner codes, defaults.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_GO     = 3'd2,
        ST_RESULT = 3'd3,
        ST_FOUL   = 3'd4,
        ST_OVER   = 3'd5
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_L    = 2'b01;
    localparam logic [1:0] WIN_R    = 2'b10;
    localparam logic [1:0] WIN_TIE  = 2'b11;

    localparam int MATCH_POINTS_DEF = 5;
    localparam int MIN_WAIT_MS_DEF  = 1000;
    localparam int TIMEOUT_MS_DEF   = 2000;

    // Counter widths: wait must hold MIN_WAIT + 2047, reaction must hold TIMEOUT.
    localparam int WAIT_W  = 12;
    localparam int REACT_W = 11;
    localparam int SCORE_W = 4;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Score increment that sticks at the match limit.
    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] v,
                                                    input logic [SCORE_W-1:0] lim);
        return (v >= lim) ? lim : v + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/u_lfsr16.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), free running, reseeded by rst.
// Latency: new value every clk.
// Backpressure: none; advances unconditionally.
// Ports: clk, rst (sync, active high), o_rnd[15:0] current register value.
module u_lfsr16
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] o_rnd
);

    logic [15:0] r_lfsr;
    logic        w_fb;

    // Right-shifting form: taps 16,14,13,11 land on bits 0,2,3,5.
    // A non-zero seed can never reach the all-zero lock-up state.
    assign w_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {w_fb, r_lfsr[15:1]};
        end
    end

    assign o_rnd = r_lfsr;

endmodule

// File: rtl/u_game_ctrl.sv
// Two-player reaction game: random pre-GO delay, reaction timing, fouls, match scoring.
// Latency: every state change takes effect on the clk edge that samples its cause.
// Backpressure: none; inputs are one-cycle pulses acted on (or ignored) in the cycle sampled.
// Ports: clk/rst; i_tick 1 ms enable; i_start, i_restart, i_play[1:0] one-shots;
//        o_state, o_go, o_winner, o_foul, o_react_ms, o_score_l/r, o_match_over.
module u_game_ctrl
    import game_pkg::*;
#(
    parameter int MATCH_POINTS = MATCH_POINTS_DEF,
    parameter int MIN_WAIT_MS  = MIN_WAIT_MS_DEF,
    parameter int TIMEOUT_MS   = TIMEOUT_MS_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_tick,
    input  logic         i_start,
    input  logic         i_restart,
    input  logic [1:0]   i_play,
    output logic [2:0]   o_state,
    output logic         o_go,
    output logic [1:0]   o_winner,
    output logic [1:0]   o_foul,
    output logic [10:0]  o_react_ms,
    output logic [3:0]   o_score_l,
    output logic [3:0]   o_score_r,
    output logic         o_match_over
);

    localparam logic [REACT_W-1:0] C_TIMEOUT = REACT_W'(TIMEOUT_MS);
    localparam logic [SCORE_W-1:0] C_MATCH   = SCORE_W'(MATCH_POINTS);

    state_t               r_state,     w_state_nxt;
    logic [WAIT_W-1:0]    r_wait_cnt,  w_wait_nxt;
    logic [REACT_W-1:0]   r_react_cnt, w_react_cnt_nxt;
    logic [1:0]           r_winner,    w_winner_nxt;
    logic [1:0]           r_foul,      w_foul_nxt;
    logic [REACT_W-1:0]   r_react_ms,  w_react_ms_nxt;
    logic [SCORE_W-1:0]   r_score_l,   w_score_l_nxt;
    logic [SCORE_W-1:0]   r_score_r,   w_score_r_nxt;
    logic                 w_begin;
    logic [15:0]          w_rnd;
    logic                 w_unused_rnd;

    u_lfsr16 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .o_rnd (w_rnd)
    );

    // Only the low 11 bits shape the delay; the rest just keep the sequence long.
    assign w_unused_rnd = ^w_rnd[15:11];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_wait_cnt  <= '0;
            r_react_cnt <= '0;
            r_winner    <= WIN_NONE;
            r_foul      <= 2'b00;
            r_react_ms  <= '0;
            r_score_l   <= '0;
            r_score_r   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_nxt;
            r_react_cnt <= w_react_cnt_nxt;
            r_winner    <= w_winner_nxt;
            r_foul      <= w_foul_nxt;
            r_react_ms  <= w_react_ms_nxt;
            r_score_l   <= w_score_l_nxt;
            r_score_r   <= w_score_r_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_wait_nxt      = r_wait_cnt;
        w_react_cnt_nxt = r_react_cnt;
        w_winner_nxt    = r_winner;
        w_foul_nxt      = r_foul;
        w_react_ms_nxt  = r_react_ms;
        w_score_l_nxt   = r_score_l;
        w_score_r_nxt   = r_score_r;
        w_begin         = 1'b0;

        if (i_restart) begin
            w_state_nxt     = ST_IDLE;
            w_wait_nxt      = '0;
            w_react_cnt_nxt = '0;
            w_winner_nxt    = WIN_NONE;
            w_foul_nxt      = 2'b00;
            w_react_ms_nxt  = '0;
            w_score_l_nxt   = '0;
            w_score_r_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: w_begin = i_start;

                ST_WAIT: begin
                    // An early press beats a countdown expiring in the same cycle.
                    if (|i_play) begin
                        w_foul_nxt  = i_play;
                        w_state_nxt = ST_FOUL;
                        if (i_play == WIN_L) w_score_r_nxt = score_inc(r_score_r, C_MATCH);
                        if (i_play == WIN_R) w_score_l_nxt = score_inc(r_score_l, C_MATCH);
                    end else if (i_tick) begin
                        if (r_wait_cnt <= WAIT_W'(1)) begin
                            w_wait_nxt      = '0;
                            w_react_cnt_nxt = '0;
                            w_state_nxt     = ST_GO;
                        end else begin
                            w_wait_nxt = r_wait_cnt - WAIT_W'(1);
                        end
                    end
                end

                ST_GO: begin
                    // A press takes the count before this cycle's tick is applied.
                    if (|i_play) begin
                        w_winner_nxt   = i_play;
                        w_react_ms_nxt = r_react_cnt;
                        w_state_nxt    = ST_RESULT;
                        if (i_play == WIN_L) w_score_l_nxt = score_inc(r_score_l, C_MATCH);
                        if (i_play == WIN_R) w_score_r_nxt = score_inc(r_score_r, C_MATCH);
                    end else if (i_tick) begin
                        if (r_react_cnt >= C_TIMEOUT - REACT_W'(1)) begin
                            w_react_cnt_nxt = C_TIMEOUT;
                            w_winner_nxt    = WIN_NONE;
                            w_react_ms_nxt  = C_TIMEOUT;
                            w_state_nxt     = ST_RESULT;
                        end else begin
                            w_react_cnt_nxt = r_react_cnt + REACT_W'(1);
                        end
                    end
                end

                ST_RESULT, ST_FOUL: begin
                    // Match end is resolved before a new round can be requested.
                    if (r_score_l == C_MATCH || r_score_r == C_MATCH) begin
                        w_state_nxt = ST_OVER;
                    end else begin
                        w_begin = i_start;
                    end
                end

                ST_OVER: ;

                default: w_state_nxt = ST_IDLE;
            endcase
        end

        if (w_begin) begin
            w_wait_nxt     = WAIT_W'(MIN_WAIT_MS) + WAIT_W'(w_rnd[10:0]);
            w_winner_nxt   = WIN_NONE;
            w_foul_nxt     = 2'b00;
            w_react_ms_nxt = '0;
            w_state_nxt    = ST_WAIT;
        end
    end

    assign o_state      = r_state;
    assign o_go         = (r_state == ST_GO);
    assign o_winner     = r_winner;
    assign o_foul       = r_foul;
    assign o_react_ms   = r_react_ms;
    assign o_score_l    = r_score_l;
    assign o_score_r    = r_score_r;
    assign o_match_over = (r_state == ST_OVER);

endmodule
